// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // IDLE: no buffered MDU results; PENDING: FIFO non-empty;
  // FORCE: one-cycle pipeline stall to drain the starved FIFO head.
  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    FORCE
  } wb_arb_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_arb_entry_t;

  // One-hot decode of a destination register number.
  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// Small synchronous FIFO of MDU results. Exposes its occupancy, the head
// entry and a per-slot valid/address view for pending-destination tracking.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  push,
  input  wb_arb_entry_t                         push_entry,
  input  logic                                  pop,
  output logic [CNT_W-1:0]                      count,
  output wb_arb_entry_t                         head,
  output logic [DEPTH-1:0]                      entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]      entry_addr
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_arb_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointer, occupancy and slot-valid bookkeeping; pointers wrap naturally
  // because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every flop in
  // this block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (push) begin
        wr_ptr              <= wr_ptr + PTR_W'(1);
        entry_valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr              <= rd_ptr + PTR_W'(1);
        entry_valid[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage.
  // NOTE: the data array is deliberately not reset; entry_valid alone says
  // which slots mean anything, so clearing the payload would only cost logic.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  assign head = mem[rd_ptr];

  // Address view of every slot for the pending-destination mask.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i] = mem[i].addr;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// writeback stream and buffered MDU results. The pipeline wins by default;
// a starvation counter forces one MDU write by stalling the pipeline.
module wb_write_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] WB_reg_write_address_i,
  input  logic [DATA_W-1:0]     WB_reg_write_data_i,
  input  logic                  WB_ctrl_reg_write_i,
  input  logic                  mdu_valid_i,
  input  logic [REG_ADDR_W-1:0] mdu_address_i,
  input  logic [DATA_W-1:0]     mdu_data_i,
  output logic                  mdu_ready_o,
  output logic                  rf_write_enable_o,
  output logic [REG_ADDR_W-1:0] rf_write_address_o,
  output logic [DATA_W-1:0]     rf_write_data_o,
  output logic                  stall_o,
  output logic [NUM_REGS-1:0]   pending_mask_o
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C       = CNT_W'(DEPTH);
  localparam logic [WAIT_W-1:0] LAST_DENIAL_C = WAIT_W'(STARVE_LIMIT - 1);

  wb_arb_state_t                    state_q;
  logic [WAIT_W-1:0]                wait_cnt_q;
  logic [CNT_W-1:0]                 fifo_count;
  logic [CNT_W-1:0]                 count_after;
  wb_arb_entry_t                    head;
  wb_arb_entry_t                    push_entry;
  logic [DEPTH-1:0]                 entry_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_addr;
  logic                             pipe_req;
  logic                             push;
  logic                             pop;
  logic                             grant_pipe;
  logic                             grant_head;
  logic [NUM_REGS-1:0]              mask_c;

  // Writes to x0 are architecturally discarded, so they never compete.
  assign pipe_req = WB_ctrl_reg_write_i && (WB_reg_write_address_i != '0);

  // Acceptance is based on registered occupancy only; a same-cycle pop does
  // not open a slot. Address-0 results are accepted and silently dropped.
  assign mdu_ready_o = !rst_i && (fifo_count < DEPTH_C);
  assign push        = mdu_valid_i && mdu_ready_o && (mdu_address_i != '0);
  assign push_entry  = '{addr: mdu_address_i, data: mdu_data_i};

  wb_arb_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk_i),
    .rst         (rst_i),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .count       (fifo_count),
    .head        (head),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // Per-cycle grant decision from the registered state and live request.
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_pipe = 1'b0;
    grant_head = 1'b0;
    if (!rst_i) begin
      case (state_q)
        FORCE:   grant_head = 1'b1;
        PENDING: begin
          if (pipe_req) grant_pipe = 1'b1;
          else          grant_head = 1'b1;
        end
        IDLE:    grant_pipe = pipe_req;
        default: ;
      endcase
    end
  end

  assign pop                = grant_head;
  assign count_after        = fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign rf_write_enable_o  = grant_pipe || grant_head;
  assign rf_write_address_o = grant_head ? head.addr : WB_reg_write_address_i;
  assign rf_write_data_o    = grant_head ? head.data : WB_reg_write_data_i;
  assign stall_o            = !rst_i && (state_q == FORCE);

  // State and starvation counter; FORCE always lasts exactly one cycle and
  // the counter clears whenever the head is written.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        FORCE: begin
          state_q    <= (count_after != '0) ? PENDING : IDLE;
          wait_cnt_q <= '0;
        end
        PENDING: begin
          if (pipe_req) begin
            if (wait_cnt_q == LAST_DENIAL_C) begin
              state_q    <= FORCE;
              wait_cnt_q <= '0;
            end else begin
              wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end
          end else begin
            state_q    <= (count_after != '0) ? PENDING : IDLE;
            wait_cnt_q <= '0;
          end
        end
        IDLE: begin
          state_q    <= (count_after != '0) ? PENDING : IDLE;
          wait_cnt_q <= '0;
        end
        default: begin
          state_q    <= IDLE;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // Destinations still owed a write by the MDU, for the hazard unit.
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) mask_c |= addr_onehot(entry_addr[i]);
    end
  end

  assign pending_mask_o = rst_i ? '0 : mask_c;

endmodule
